// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first. A byte is taken on a valid/ready handshake in IDLE,
// and a one-cycle tx_done pulse marks the return to IDLE.
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       Tx_Serial,
   output logic       tx_active,
   output logic       tx_done
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } state_t;

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [2:0]       bit_idx, bit_idx_d;
   logic [7:0]       shift, shift_d;
   logic             serial_d, ready_d, active_d, done_d;
   logic             bit_end;

   assign bit_end = (cnt == CNT_MAX);

   // Outputs are computed one cycle ahead so that every port comes straight from a flop.
   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      bit_idx_d = bit_idx;
      shift_d   = shift;
      serial_d  = Tx_Serial;
      ready_d   = tx_ready;
      active_d  = tx_active;
      done_d    = 1'b0;
      case (state)
         IDLE: begin
            serial_d  = 1'b1;
            ready_d   = 1'b1;
            active_d  = 1'b0;
            cnt_d     = '0;
            bit_idx_d = '0;
            if (tx_valid && tx_ready) begin
               shift_d  = tx_data;
               state_d  = START;
               serial_d = 1'b0;
               ready_d  = 1'b0;
               active_d = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               cnt_d    = '0;
               state_d  = DATA;
               serial_d = shift[0];
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_idx == 3'd7) begin
                  state_d  = STOP;
                  serial_d = 1'b1;
               end else begin
                  // bit 0 of shift is always the bit currently on the line
                  bit_idx_d = bit_idx + 1'b1;
                  shift_d   = {1'b0, shift[7:1]};
                  serial_d  = shift[1];
               end
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_d    = '0;
               state_d  = IDLE;
               serial_d = 1'b1;
               ready_d  = 1'b1;
               active_d = 1'b0;
               done_d   = 1'b1;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         default: begin
            state_d   = IDLE;
            cnt_d     = '0;
            bit_idx_d = '0;
            serial_d  = 1'b1;
            ready_d   = 1'b1;
            active_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         Tx_Serial <= 1'b1;
         tx_ready  <= 1'b1;
         tx_active <= 1'b0;
         tx_done   <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         bit_idx   <= bit_idx_d;
         shift     <= shift_d;
         Tx_Serial <= serial_d;
         tx_ready  <= ready_d;
         tx_active <= active_d;
         tx_done   <= done_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a scoreboard queue fed at acceptance, a cycle-exact line monitor at
// CLKS_PER_BIT=4, and a mid-bit sampling receiver on a second instance at CLKS_PER_BIT=868.
module tb_uart_tx;

   localparam int CPB    = 4;
   localparam int LB_CPB = 868;
   localparam int FRAME  = 10 * CPB;

   typedef struct {
      logic [7:0] b;
      int         acc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready, Tx_Serial, tx_active, tx_done;
   logic [7:0] lb_data;
   logic       lb_valid;
   logic       lb_ready, lb_serial, lb_active, lb_done;

   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t exp_q[$];
   logic [7:0] lb_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx #(.CLKS_PER_BIT(CPB)) u_dut (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .Tx_Serial(Tx_Serial), .tx_active(tx_active), .tx_done(tx_done)
   );

   uart_tx #(.CLKS_PER_BIT(LB_CPB)) u_lb (
      .clk(clk), .rst_n(rst_n), .tx_data(lb_data), .tx_valid(lb_valid),
      .tx_ready(lb_ready), .Tx_Serial(lb_serial), .tx_active(lb_active), .tx_done(lb_done)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Expects to be entered just after a rising edge; returns just after the edge that follows acceptance.
   task automatic send(input logic [7:0] b, input bit hold, output int acc_cyc);
      bit acc = 1'b0;
      acc_cyc  = -1;
      tx_data  = b;
      tx_valid = 1'b1;
      for (int n = 0; n < 200 && !acc; n++) begin
         @(negedge clk);
         if (tx_ready === 1'b1) begin
            acc     = 1'b1;
            acc_cyc = cyc;
            exp_q.push_back('{b, cyc});
         end
         @(posedge clk); #1;
      end
      if (!hold) tx_valid = 1'b0;
      check("accept", 32'(acc), 32'd1);
   endtask

   task automatic send_lb(input logic [7:0] b);
      bit acc  = 1'b0;
      bit seen = 1'b0;
      lb_data  = b;
      lb_valid = 1'b1;
      for (int n = 0; n < 200 && !acc; n++) begin
         @(negedge clk);
         if (lb_ready === 1'b1) begin
            acc = 1'b1;
            lb_q.push_back(b);
         end
         @(posedge clk); #1;
      end
      lb_valid = 1'b0;
      check("lb_accept", 32'(acc), 32'd1);
      for (int n = 0; n < 10 * LB_CPB + 20 && !seen; n++) begin
         @(negedge clk);
         if (lb_done === 1'b1) seen = 1'b1;
      end
      check("lb_done_seen", 32'(seen), 32'd1);
      @(posedge clk); #1;
   endtask

   // Cycle-exact monitor for the CPB=4 instance.
   initial begin
      logic       line_s[FRAME];
      exp_t       e;
      int         start_cyc, bad_line, bad_ctl, slot;
      bit         aborted;
      logic [7:0] got_b;
      logic       want;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) continue;
         if (Tx_Serial === 1'b0) begin
            start_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("unexpected_frame", 32'd1, 32'd0);
               e = '{8'h00, -100};
            end else begin
               e = exp_q.pop_front();
            end
            check("start_latency", 32'(start_cyc - e.acc), 32'd1);
            bad_ctl   = (tx_active === 1'b1 && tx_ready === 1'b0 && tx_done === 1'b0) ? 0 : 1;
            line_s[0] = Tx_Serial;
            aborted   = 1'b0;
            for (int k = 1; k < FRAME; k++) begin
               @(negedge clk);
               if (rst_n !== 1'b1) begin
                  aborted = 1'b1;
                  break;
               end
               line_s[k] = Tx_Serial;
               if (!(tx_active === 1'b1 && tx_ready === 1'b0 && tx_done === 1'b0)) bad_ctl++;
            end
            if (aborted) continue;
            bad_line = 0;
            for (int k = 0; k < FRAME; k++) begin
               slot = k / CPB;
               want = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : e.b[slot-1];
               if (line_s[k] !== want) bad_line++;
            end
            for (int i = 0; i < 8; i++) got_b[i] = line_s[(i + 1) * CPB + CPB / 2];
            check("frame_byte", 32'(got_b), 32'(e.b));
            check("frame_samples_bad", 32'(bad_line), 32'd0);
            check("frame_ctrl_bad", 32'(bad_ctl), 32'd0);
            @(negedge clk);
            if (rst_n !== 1'b1) continue;
            check("done_cycle_{done,ready,active,line}",
                  32'({tx_done, tx_ready, tx_active, Tx_Serial}), 32'b1101);
         end else begin
            check("idle_{done,ready,active}", 32'({tx_done, tx_ready, tx_active}), 32'b010);
         end
      end
   end

   // Mid-bit sampling receiver on the CPB=868 line.
   initial begin
      logic [7:0] d;
      logic       st, sp;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && lb_serial === 1'b0) begin
            repeat (LB_CPB / 2) @(negedge clk);
            st = lb_serial;
            for (int i = 0; i < 8; i++) begin
               repeat (LB_CPB) @(negedge clk);
               d[i] = lb_serial;
            end
            repeat (LB_CPB) @(negedge clk);
            sp = lb_serial;
            check("rx_data_valid", 32'({st, sp}), 32'b01);
            if (lb_q.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
            else check("rx_byte", 32'(d), 32'(lb_q.pop_front()));
         end
      end
   end

   initial begin
      int a1, a2;
      rst_n    = 1'b0;
      tx_valid = 1'b1;
      tx_data  = 8'h5A;
      lb_valid = 1'b0;
      lb_data  = 8'h00;

      // reset with tx_valid held high
      repeat (3) begin
         @(negedge clk);
         check("reset_{line,ready,active,done}",
               32'({Tx_Serial, tx_ready, tx_active, tx_done}), 32'b1100);
      end
      check("reset_lb_{line,ready,active,done}",
            32'({lb_serial, lb_ready, lb_active, lb_done}), 32'b1100);
      @(posedge clk); #1;
      tx_valid = 1'b0;
      rst_n    = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // single byte, tx_done at cycle 41 checked by monitor
      send(8'hA5, 1'b0, a1);
      repeat (45) @(posedge clk);
      #1;

      // back-to-back: second byte taken in the tx_done cycle
      send(8'h00, 1'b1, a1);
      send(8'hFF, 1'b0, a2);
      check("b2b_accept_offset", 32'(a2 - a1), 32'(FRAME + 1));
      repeat (45) @(posedge clk);
      #1;

      // reset during bit 3 of 0x3C
      send(8'h3C, 1'b0, a1);
      repeat (17) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort_{line,ready,active,done}",
            32'({Tx_Serial, tx_ready, tx_active, tx_done}), 32'b1100);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("abort_no_done", 32'(tx_done), 32'd0);
      end
      @(posedge clk); #1;
      send(8'h81, 1'b0, a1);
      repeat (45) @(posedge clk);
      #1;

      // data and valid changing mid-frame must not disturb the latched byte
      send(8'h12, 1'b1, a1);
      tx_data = 8'hFF;
      repeat (20) @(posedge clk);
      #1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (30) @(posedge clk);
      #1;

      // loopback at full baud divisor
      send_lb(8'h3C);
      send_lb(8'h00);
      send_lb(8'hFF);
      repeat (20) @(posedge clk);

      check("pending_frames", 32'(exp_q.size()), 32'd0);
      check("pending_lb_bytes", 32'(lb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
